regfile_mp: RTL and testbench



---
 rtl/regfile_mp_if.sv | 33 +++
 rtl/regfile_mp.sv | 122 ++++++++++++
 tb/tb_regfile_mp.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Register file bus: read ports, write ports, scoreboard set
// and the registered read/busy/count results.
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                sb_set;
    logic [AW-1:0]       sb_addr;
    logic [AW:0]         busy_cnt;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output sb_set, sb_addr,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  sb_set, sb_addr,
        output rd_data, rd_busy, busy_cnt
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with pending-write
// busy scoreboard and optional write-first bypass.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic         clk,
    input logic         rstn,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = AW + 1;

    logic [XLEN-1:0]     regs_q [NREGS];
    logic [NREGS-1:0]    busy_q, busy_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NRD*XLEN-1:0] rdat_q, rdat_d;
    logic [NRD-1:0]      rbsy_q, rbsy_d;

    logic [NWR-1:0]  wv;
    logic [AW-1:0]   wa [NWR];
    logic [XLEN-1:0] wd [NWR];
    logic            sv;
    logic [AW-1:0]   sa;

    // Unpack write ports and drop anything aimed at a hardwired x0
    always_comb begin
        for (int w = 0; w < NWR; w++) begin
            wa[w] = bus.wr_addr[w*AW +: AW];
            wd[w] = bus.wr_data[w*XLEN +: XLEN];
            wv[w] = bus.wr_en[w] &&
                    !((ZERO_REG != 0) && (wa[w] == '0));
        end
        sa = bus.sb_addr;
        sv = bus.sb_set && !((ZERO_REG != 0) && (sa == '0));
    end

    // Busy vector update (clear on write, set wins) and net count
    always_comb begin
        int unsigned inc;
        int unsigned dec;
        logic        dup;
        busy_d = busy_q;
        inc    = 0;
        dec    = 0;
        dup    = 1'b0;
        for (int w = 0; w < NWR; w++) begin
            if (wv[w]) begin
                busy_d[wa[w]] = 1'b0;
                dup = 1'b0;
                for (int v = 0; v < w; v++) begin
                    if (wv[v] && (wa[v] == wa[w])) dup = 1'b1;
                end
                if (busy_q[wa[w]] && !dup &&
                    !(sv && (sa == wa[w]))) dec = dec + 1;
            end
        end
        if (sv) begin
            busy_d[sa] = 1'b1;
            if (!busy_q[sa]) inc = 1;
        end
        cnt_d = cnt_q + CW'(inc) - CW'(dec);
    end

    // Read ports: old or write-first data, held while disabled
    always_comb begin
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            b;
        rdat_d = rdat_q;
        rbsy_d = rbsy_q;
        a = '0;
        d = '0;
        b = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            a = bus.rd_addr[i*AW +: AW];
            d = regs_q[a];
            b = busy_q[a];
            if (BYPASS != 0) begin
                for (int w = 0; w < NWR; w++) begin
                    if (wv[w] && (wa[w] == a)) d = wd[w];
                end
                b = busy_d[a];
            end
            if ((ZERO_REG != 0) && (a == '0)) begin
                d = '0;
                b = 1'b0;
            end
            if (bus.rd_en[i]) begin
                rdat_d[i*XLEN +: XLEN] = d;
                rbsy_d[i] = b;
            end
        end
    end

    // State update; later write ports overwrite earlier ones
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
            rdat_q <= '0;
            rbsy_q <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wv[w]) regs_q[wa[w]] <= wd[w];
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rdat_q <= rdat_d;
            rbsy_q <= rbsy_d;
        end
    end

    assign bus.rd_data  = rdat_q;
    assign bus.rd_busy  = rbsy_q;
    assign bus.busy_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: one write-first and one read-old
// instance driven in lockstep against an array model.
module tb_regfile_mp;
    localparam int XLEN = 32;
    localparam int NR   = 32;
    localparam int AW   = 5;

    logic              clk = 1'b0;
    logic              rstn;
    logic [1:0]        rd_en;
    logic [2*AW-1:0]   rd_addr;
    logic [1:0]        wr_en;
    logic [2*AW-1:0]   wr_addr;
    logic [2*XLEN-1:0] wr_data;
    logic              sb_set;
    logic [AW-1:0]     sb_addr;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NR)) if1 ();
    regfile_mp_if #(.XLEN(XLEN), .NREGS(NR)) if0 ();

    assign if1.rd_en   = rd_en;
    assign if1.rd_addr = rd_addr;
    assign if1.wr_en   = wr_en;
    assign if1.wr_addr = wr_addr;
    assign if1.wr_data = wr_data;
    assign if1.sb_set  = sb_set;
    assign if1.sb_addr = sb_addr;
    assign if0.rd_en   = rd_en;
    assign if0.rd_addr = rd_addr;
    assign if0.wr_en   = wr_en;
    assign if0.wr_addr = wr_addr;
    assign if0.wr_data = wr_data;
    assign if0.sb_set  = sb_set;
    assign if0.sb_addr = sb_addr;

    regfile_mp #(.BYPASS(1)) u_byp (
        .clk(clk), .rstn(rstn), .bus(if1));
    regfile_mp #(.BYPASS(0)) u_old (
        .clk(clk), .rstn(rstn), .bus(if0));

    int checks = 0;
    int passes = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            passes++;
    endtask

    // Model: plain register array, busy flags, expected read results
    logic [XLEN-1:0] m_regs [NR];
    logic [NR-1:0]   m_busy;
    logic [XLEN-1:0] m_d1 [2];
    logic [XLEN-1:0] m_d0 [2];
    logic            m_b1 [2];
    logic            m_b0 [2];

    initial begin
        for (int k = 0; k < NR; k++) m_regs[k] = '0;
        m_busy = '0;
        for (int i = 0; i < 2; i++) begin
            m_d1[i] = '0; m_d0[i] = '0; m_b1[i] = 0; m_b0[i] = 0;
        end
    end

    always @(posedge clk) begin
        int a, wa;
        logic [XLEN-1:0] nw;
        logic hit;
        if (!rstn) begin
            for (int k = 0; k < NR; k++) m_regs[k] = '0;
            m_busy = '0;
            for (int i = 0; i < 2; i++) begin
                m_d1[i] = '0; m_d0[i] = '0;
                m_b1[i] = 0;  m_b0[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (rd_en[i]) begin
                    a = int'(rd_addr[i*AW +: AW]);
                    if (a == 0) begin
                        m_d1[i] = '0; m_d0[i] = '0;
                        m_b1[i] = 0;  m_b0[i] = 0;
                    end else begin
                        nw  = m_regs[a];
                        hit = 0;
                        for (int w = 0; w < 2; w++)
                            if (wr_en[w] &&
                                int'(wr_addr[w*AW +: AW]) == a) begin
                                nw  = wr_data[w*XLEN +: XLEN];
                                hit = 1;
                            end
                        m_d0[i] = m_regs[a];
                        m_b0[i] = m_busy[a];
                        m_d1[i] = nw;
                        if (sb_set && int'(sb_addr) == a) m_b1[i] = 1;
                        else if (hit) m_b1[i] = 0;
                        else m_b1[i] = m_busy[a];
                    end
                end
            end
            for (int w = 0; w < 2; w++) begin
                wa = int'(wr_addr[w*AW +: AW]);
                if (wr_en[w] && wa != 0) begin
                    m_regs[wa] = wr_data[w*XLEN +: XLEN];
                    m_busy[wa] = 0;
                end
            end
            if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1;
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("rd_data_byp", 64'(if1.rd_data), {m_d1[1], m_d1[0]});
            chk("rd_data_old", 64'(if0.rd_data), {m_d0[1], m_d0[0]});
            chk("rd_busy_byp", 64'(if1.rd_busy), 64'({m_b1[1], m_b1[0]}));
            chk("rd_busy_old", 64'(if0.rd_busy), 64'({m_b0[1], m_b0[0]}));
            chk("cnt_byp", 64'(if1.busy_cnt), 64'($countones(m_busy)));
            chk("cnt_old", 64'(if0.busy_cnt), 64'($countones(m_busy)));
        end
    end

    task automatic clr();
        rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0;
        wr_data = '0; sb_set = 1'b0; sb_addr = '0;
    endtask

    task automatic rd(input int p, input int a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic sb(input int a);
        sb_set = 1'b1;
        sb_addr = AW'(a);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0;
        clr();
        tick();
        chk_on = 1'b1;
        tick();
        rstn = 1'b1;
        chk("reset_cnt", 64'(if1.busy_cnt), 64'd0);
        chk("reset_data", 64'(if1.rd_data), 64'd0);

        for (int a = 0; a < NR; a++) begin
            clr(); rd(0, a); rd(1, NR - 1 - a); tick();
        end
        chk("all_zero", 64'(if0.rd_data), 64'd0);

        clr(); wr(0, 0, 32'hDEADBEEF); tick();
        clr(); rd(0, 0); rd(1, 0); tick();
        chk("x0_zero", 64'(if1.rd_data), 64'd0);

        clr(); wr(0, 5, 32'h11); wr(1, 6, 32'h22); tick();
        clr(); wr(0, 7, 32'hAA); wr(1, 7, 32'hBB); tick();
        clr(); rd(0, 5); rd(1, 6); tick();
        chk("x5", 64'(if0.rd_data[31:0]), 64'h11);
        chk("x6", 64'(if0.rd_data[63:32]), 64'h22);
        clr(); rd(0, 7); tick();
        chk("x7_collide", 64'(if0.rd_data[31:0]), 64'hBB);

        clr(); wr(0, 3, 32'h1234); rd(0, 3); tick();
        chk("bypass_new", 64'(if1.rd_data[31:0]), 64'h1234);
        chk("readold_old", 64'(if0.rd_data[31:0]), 64'h0);
        clr(); rd(0, 3); tick();
        chk("readold_next", 64'(if0.rd_data[31:0]), 64'h1234);

        clr(); sb(8); rd(0, 8); tick();
        chk("sb_busy_byp", 64'(if1.rd_busy[0]), 64'd1);
        chk("sb_busy_old", 64'(if0.rd_busy[0]), 64'd0);
        chk("sb_cnt1", 64'(if1.busy_cnt), 64'd1);
        clr(); wr(0, 8, 32'h5); sb(8); rd(0, 8); tick();
        chk("sb_coll_data", 64'(if1.rd_data[31:0]), 64'h5);
        chk("sb_coll_busy", 64'(if1.rd_busy[0]), 64'd1);
        chk("sb_coll_cnt", 64'(if1.busy_cnt), 64'd1);
        clr(); rd(0, 8); tick();
        chk("sb_old_busy", 64'(if0.rd_busy[0]), 64'd1);
        clr(); wr(1, 8, 32'h6); rd(0, 8); tick();
        chk("sb_clr_busy", 64'(if1.rd_busy[0]), 64'd0);
        chk("sb_clr_cnt", 64'(if1.busy_cnt), 64'd0);

        clr(); rd(1, 5); tick();
        chk("hold_pre", 64'(if1.rd_data[63:32]), 64'h11);
        clr(); rd_addr[AW +: AW] = 5'd5; wr(0, 5, 32'h99); tick();
        chk("hold_1", 64'(if1.rd_data[63:32]), 64'h11);
        clr(); rd_addr[AW +: AW] = 5'd5; tick();
        chk("hold_2", 64'(if0.rd_data[63:32]), 64'h11);
        clr(); rd(1, 5); tick();
        chk("hold_release", 64'(if1.rd_data[63:32]), 64'h99);

        for (int a = 0; a < NR; a++) begin
            clr(); sb(a); tick();
        end
        chk("cnt_max", 64'(if1.busy_cnt), 64'd31);
        clr(); wr(0, 12, 32'h12); wr(1, 12, 32'h34); tick();
        chk("dup_clear_cnt", 64'(if1.busy_cnt), 64'd30);
        for (int a = 1; a < NR; a += 2) begin
            clr(); wr(0, a, 32'(a)); wr(1, a + 1 < NR ? a + 1 : 0,
                                        32'(a + 100)); tick();
        end
        chk("cnt_drained", 64'(if1.busy_cnt), 64'd0);

        clr(); sb(8); tick();
        clr(); rstn = 1'b0; sb(9); wr(0, 10, 32'h7); tick();
        rstn = 1'b1;
        chk("rst_cnt", 64'(if1.busy_cnt), 64'd0);
        clr(); rd(0, 9); rd(1, 10); tick();
        chk("rst_x9_busy", 64'(if1.rd_busy), 64'd0);
        chk("rst_x10_data", 64'(if1.rd_data[63:32]), 64'd0);
        clr(); rd(0, 8); rd(1, 5); tick();
        chk("rst_x5_data", 64'(if0.rd_data[63:32]), 64'd0);
        chk("rst_x8_busy", 64'(if0.rd_busy[0]), 64'd0);

        clr(); tick();
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
